rv_commit_checker: RTL

Synthesisable lockstep commit checker for the RV32I datapath. It takes the retire stream of the DUT core and the retire stream of a reference source (golden model or second core instance). It buffers each stream in its own FIFO, compares retirements in order, and latches the first divergence with a cause code and PC. It sits beside `DATAPATH` in simulation and FPGA self-test builds, and replaces per-cycle model calls in the bench with a clocked, decoupled comparison.

---
 rtl/rv_commit_checker.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv_commit_checker.sv
// Lockstep retire-stream checker: buffers DUT and reference retirements, compares them
// in order and latches the first divergence with a cause code and PC.

module rv_commit_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wp <= '0;
            rp <= '0;
        end else if (i_clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (i_push) wp <= wp + 1'b1;
            if (i_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wp[AW-1:0]] <= i_data;
    end

    assign o_data  = mem[rp[AW-1:0]];
    assign o_empty = (wp == rp);
    // Extra pointer bit tells full from empty when the index bits coincide.
    assign o_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module rv_commit_checker #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_dut_valid,
    input  logic [XLEN-1:0]  i_dut_pc,
    input  logic             i_dut_we,
    input  logic [4:0]       i_dut_rd,
    input  logic [XLEN-1:0]  i_dut_wdata,
    input  logic             i_ref_valid,
    input  logic [XLEN-1:0]  i_ref_pc,
    input  logic             i_ref_we,
    input  logic [4:0]       i_ref_rd,
    input  logic [XLEN-1:0]  i_ref_wdata,
    output logic             o_busy,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic [XLEN-1:0]  o_err_pc,
    output logic [CNT_W-1:0] o_cmp_cnt
);
    // state  | meaning
    // S_RUN  | accepting pushes, popping pairs and comparing
    // S_FAIL | divergence latched; FIFOs, counter and error fields frozen
    typedef enum logic {S_RUN, S_FAIL} state_t;

    localparam int EW   = XLEN + 1 + 5 + XLEN;
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t state;
    state_t state_nxt;

    logic          dut_empty, dut_full, ref_empty, ref_full;
    logic [EW-1:0] dut_head, ref_head;
    logic          run, pop, dut_push, ref_push, dut_ovf, ref_ovf;

    logic [XLEN-1:0] dh_pc, dh_wd, rh_pc, rh_wd;
    logic            dh_we, rh_we;
    logic [4:0]      dh_rd, rh_rd;

    logic            cmp_vld;
    logic [XLEN-1:0] cd_pc, cd_wd, cr_pc, cr_wd;
    logic            cd_we, cr_we;
    logic [4:0]      cd_rd, cr_rd;

    logic            c_pc, c_ctl, c_dat, match;
    logic [TO_W-1:0] to_cnt;
    logic            one_ne, to_hit;

    logic            err_any;
    logic [2:0]      err_code_nxt;
    logic [XLEN-1:0] err_pc_nxt;

    assign run = (state == S_RUN);
    assign pop = run && !dut_empty && !ref_empty;

    // A full FIFO still accepts a push when it pops in the same cycle.
    assign dut_push = run && i_dut_valid && (!dut_full || pop);
    assign ref_push = run && i_ref_valid && (!ref_full || pop);
    assign dut_ovf  = run && i_dut_valid && dut_full && !pop;
    assign ref_ovf  = run && i_ref_valid && ref_full && !pop;

    rv_commit_fifo #(.W(EW), .DEPTH(DEPTH)) u_dut_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clr   (i_clr),
        .i_push  (dut_push),
        .i_pop   (pop),
        .i_data  ({i_dut_pc, i_dut_we, i_dut_rd, i_dut_wdata}),
        .o_data  (dut_head),
        .o_empty (dut_empty),
        .o_full  (dut_full)
    );

    rv_commit_fifo #(.W(EW), .DEPTH(DEPTH)) u_ref_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clr   (i_clr),
        .i_push  (ref_push),
        .i_pop   (pop),
        .i_data  ({i_ref_pc, i_ref_we, i_ref_rd, i_ref_wdata}),
        .o_data  (ref_head),
        .o_empty (ref_empty),
        .o_full  (ref_full)
    );

    assign {dh_pc, dh_we, dh_rd, dh_wd} = dut_head;
    assign {rh_pc, rh_we, rh_rd, rh_wd} = ref_head;

    // wdata only matters when it actually lands in a non-zero register.
    assign c_pc  = cmp_vld && (cd_pc != cr_pc);
    assign c_ctl = cmp_vld && ((cd_we != cr_we) || (cd_we && (cd_rd != cr_rd)));
    assign c_dat = cmp_vld && cd_we && (cd_rd != 5'd0) && (cd_wd != cr_wd);
    assign match = cmp_vld && !c_pc && !c_ctl && !c_dat;

    assign one_ne = dut_empty ^ ref_empty;
    assign to_hit = (TIMEOUT != 0) && run && one_ne && (to_cnt == TO_LAST);

    always_comb begin
        err_any      = 1'b0;
        err_code_nxt = 3'd0;
        err_pc_nxt   = '0;
        if (run) begin
            if (c_pc) begin
                err_any = 1'b1; err_code_nxt = 3'd1; err_pc_nxt = cd_pc;
            end else if (c_ctl) begin
                err_any = 1'b1; err_code_nxt = 3'd2; err_pc_nxt = cd_pc;
            end else if (c_dat) begin
                err_any = 1'b1; err_code_nxt = 3'd3; err_pc_nxt = cd_pc;
            end else if (dut_ovf) begin
                err_any = 1'b1; err_code_nxt = 3'd4; err_pc_nxt = i_dut_pc;
            end else if (ref_ovf) begin
                err_any = 1'b1; err_code_nxt = 3'd5; err_pc_nxt = '0;
            end else if (to_hit) begin
                err_any = 1'b1; err_code_nxt = 3'd6;
                err_pc_nxt = dut_empty ? rh_pc : dh_pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (err_any) state_nxt = S_FAIL;
            S_FAIL:  state_nxt = S_FAIL;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= S_RUN;
        end else if (i_clr) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cmp_vld <= 1'b0;
            cd_pc <= '0; cd_we <= 1'b0; cd_rd <= '0; cd_wd <= '0;
            cr_pc <= '0; cr_we <= 1'b0; cr_rd <= '0; cr_wd <= '0;
        end else if (i_clr) begin
            cmp_vld <= 1'b0;
        end else begin
            cmp_vld <= pop;
            if (pop) begin
                cd_pc <= dh_pc; cd_we <= dh_we; cd_rd <= dh_rd; cd_wd <= dh_wd;
                cr_pc <= rh_pc; cr_we <= rh_we; cr_rd <= rh_rd; cr_wd <= rh_wd;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_err      <= 1'b0;
            o_err_code <= 3'd0;
            o_err_pc   <= '0;
            o_cmp_cnt  <= '0;
            to_cnt     <= '0;
        end else if (i_clr) begin
            o_err      <= 1'b0;
            o_err_code <= 3'd0;
            o_err_pc   <= '0;
            o_cmp_cnt  <= '0;
            to_cnt     <= '0;
        end else begin
            if (err_any) begin
                o_err      <= 1'b1;
                o_err_code <= err_code_nxt;
                o_err_pc   <= err_pc_nxt;
            end
            if (run && match && !(&o_cmp_cnt)) o_cmp_cnt <= o_cmp_cnt + 1'b1;
            if ((TIMEOUT != 0) && run && one_ne && !to_hit) to_cnt <= to_cnt + 1'b1;
            else                                           to_cnt <= '0;
        end
    end

    assign o_busy = !dut_empty || !ref_empty || cmp_vld;
endmodule
